// File: rtl/mmio_io_pkg.sv
// Shared constants for the MIPS150 memory-mapped IO responder:
// register offsets within IO space and STATUS bit positions.
package mmio_io_pkg;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h10;
  localparam logic [7:0] OFF_INSTRS = 8'h14;
  localparam logic [7:0] OFF_CTRCLR = 8'h18;

  localparam int unsigned ST_TX_READY = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_OVF   = 2;
  localparam int unsigned ST_RX_OVR   = 3;

endpackage

// File: rtl/io_tx_fifo.sv
// Circular-buffer FIFO with extra-MSB pointers; head is the oldest entry.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module io_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mmio_io_responder.sv
// IO-space target for the MIPS150 core: UART TX FIFO, RX holding register,
// sticky error flags and cycle/instruction counters, with combinational reads.
module mmio_io_responder
  import mmio_io_pkg::*;
#(
  parameter int unsigned TX_DEPTH       = 4,
  parameter logic [3:0]  IO_BASE_NIBBLE = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [3:0]  store_mask,
  input  logic [31:0] wdata,
  input  logic        load_sel,
  output logic [31:0] rdata,
  input  logic        instr_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  logic        hit, st_act, ld_act;
  logic [7:0]  off;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic        rx_pop;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] instrs_q, instrs_d;
  logic        ctr_clr;
  logic        unused_ok;

  assign hit    = (addr[31:28] == IO_BASE_NIBBLE);
  assign off    = addr[7:0];
  assign st_act = hit && (store_mask != 4'b0000);
  assign ld_act = hit && load_sel;

  assign tx_push  = st_act && (off == OFF_TXDATA) && store_mask[0];
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_drop  = tx_push && tx_full && !tx_pop;
  assign rx_pop   = ld_act && (off == OFF_RXDATA) && rx_full_q;
  assign ctr_clr  = st_act && (off == OFF_CTRCLR);

  assign unused_ok = ^{addr[27:8], wdata[31:8], store_mask[3:1]};

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (wdata[7:0]),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_data)
  );

  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    tx_ovf_d  = tx_ovf_q;
    rx_ovr_d  = rx_ovr_q;
    if (st_act && (off == OFF_STATUS)) begin
      tx_ovf_d = 1'b0;
      rx_ovr_d = 1'b0;
    end
    if (tx_drop) tx_ovf_d = 1'b1;
    // A byte arriving alongside a pop replaces the one being consumed.
    if (rx_valid && (!rx_full_q || rx_pop)) begin
      rx_data_d = rx_data;
      rx_full_d = 1'b1;
    end else if (rx_valid) begin
      rx_ovr_d = 1'b1;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end
    cycles_d = ctr_clr ? '0 : cycles_q + 32'd1;
    instrs_d = ctr_clr ? '0 : (instr_retire ? instrs_q + 32'd1 : instrs_q);
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          rdata[ST_TX_READY] = !tx_full;
          rdata[ST_RX_FULL]  = rx_full_q;
          rdata[ST_TX_OVF]   = tx_ovf_q;
          rdata[ST_RX_OVR]   = rx_ovr_q;
        end
        OFF_RXDATA: rdata = {24'b0, rx_data_q};
        OFF_CYCLES: rdata = cycles_q;
        OFF_INSTRS: rdata = instrs_q;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      cycles_q  <= '0;
      instrs_q  <= '0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
      cycles_q  <= cycles_d;
      instrs_q  <= instrs_d;
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mmio_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [3:0]  store_mask;
  logic [31:0] wdata;
  logic        load_sel;
  logic [31:0] rdata;
  logic        instr_retire;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  localparam int K_RDATA = 0;
  localparam int K_TXV   = 1;
  localparam int K_TXVD  = 2;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t       sb_q[$];
  logic [7:0] tx_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         probe_n     = 0;

  always #5 clk = ~clk;

  mmio_io_responder #(
    .TX_DEPTH       (4),
    .IO_BASE_NIBBLE (4'h8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .store_mask   (store_mask),
    .wdata        (wdata),
    .load_sel     (load_sel),
    .rdata        (rdata),
    .instr_retire (instr_retire),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid)
  );

  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    logic [7:0]  eb;
    for (int i = 0; i < probe_n; i++) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow actual=probe required=queued_entry");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RDATA: act = rdata;
          K_TXV:   act = {31'b0, tx_valid};
          default: act = {23'b0, tx_valid, tx_data};
        endcase
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      vectors++;
      if (tx_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected actual=%h required=no_transfer", tx_data);
      end else begin
        eb = tx_q.pop_front();
        if (tx_data !== eb) begin
          miscompares++;
          $display("FAIL tx_byte actual=%h required=%h", tx_data, eb);
        end
      end
    end
  end

  task automatic clear_inputs();
    addr       = '0;
    store_mask = '0;
    wdata      = '0;
    load_sel   = 1'b0;
    rx_valid   = 1'b0;
    probe_n    = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_chk(input int kind, input string nm, input logic [31:0] exp);
    chk_t e;
    e.kind = kind;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
    probe_n++;
  endtask

  task automatic rd(input logic [7:0] off, input string nm, input logic [31:0] exp);
    addr     = {4'h8, 20'h0, off};
    load_sel = 1'b1;
    expect_chk(K_RDATA, nm, exp);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] mask, input logic [31:0] d);
    addr       = {4'h8, 20'h0, off};
    store_mask = mask;
    wdata      = d;
  endtask

  initial begin
    int guard;
    rst_n        = 1'b0;
    tx_ready     = 1'b0;
    instr_retire = 1'b0;
    rx_data      = '0;
    clear_inputs();

    #2;
    rd(8'h00, "rst_status", 32'h1);
    @(negedge clk);
    #1;
    probe_n = 0;
    rd(8'h10, "rst_cycles", 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    clear_inputs();

    repeat (10) step();
    rd(8'h10, "cycles_10", 32'd10);
    step(); rd(8'h14, "instrs_idle", 32'd0);
    step(); rd(8'h00, "status_idle", 32'h1);

    // single byte through the TX path
    step(); wr(8'h08, 4'b0001, 32'h0000_0041);
    step(); expect_chk(K_TXVD, "tx_first", 32'h141);
    tx_ready = 1'b1; tx_q.push_back(8'h41);
    step(); tx_ready = 1'b0; expect_chk(K_TXV, "tx_drained", 32'h0);
    step(); wr(8'h08, 4'b0010, 32'h0000_9900);
    step(); expect_chk(K_TXV, "tx_mask_ignored", 32'h0);

    // overflow: five pushes into four entries
    for (int b = 1; b <= 5; b++) begin
      step(); wr(8'h08, 4'b0001, b);
    end
    step(); rd(8'h00, "status_full_ovf", 32'h4);
    for (int b = 1; b <= 4; b++) tx_q.push_back(b[7:0]);
    tx_ready = 1'b1;
    repeat (3) step();
    step(); tx_ready = 1'b0;
    expect_chk(K_TXV, "tx_empty_after_drain", 32'h0);
    rd(8'h00, "status_ovf_sticky", 32'h5);
    step(); wr(8'h00, 4'b1111, 32'h0);
    step(); rd(8'h00, "status_cleared", 32'h1);

    // push while full with a same-cycle pop is accepted
    for (int b = 8'h11; b <= 8'h14; b++) begin
      step(); wr(8'h08, 4'b0001, b);
    end
    for (int b = 8'h11; b <= 8'h15; b++) tx_q.push_back(b[7:0]);
    step(); tx_ready = 1'b1; wr(8'h08, 4'b0001, 32'h15);
    repeat (4) step();
    step(); tx_ready = 1'b0;
    expect_chk(K_TXV, "tx_empty_full_pop", 32'h0);
    rd(8'h00, "status_no_ovf", 32'h1);

    // RX holding register
    step(); rx_valid = 1'b1; rx_data = 8'h5A;
    step(); rd(8'h00, "status_rx_full", 32'h3);
    step(); rx_valid = 1'b1; rx_data = 8'h77;
    step(); rd(8'h00, "status_rx_ovr", 32'hB);
    step(); rd(8'h04, "rxdata_kept", 32'h5A);
    step(); rd(8'h00, "status_rx_popped", 32'h9);
    step(); wr(8'h00, 4'b0001, 32'h0);
    step(); rd(8'h00, "status_ovr_clr", 32'h1);
    step(); rx_valid = 1'b1; rx_data = 8'h22;
    step(); rd(8'h04, "rxdata_pop_coinc", 32'h22);
    rx_valid = 1'b1; rx_data = 8'h33;
    step(); rd(8'h00, "status_coinc", 32'h3);
    step(); rd(8'h04, "rxdata_new", 32'h33);
    step(); rd(8'h04, "rxdata_stale", 32'h33);
    step(); rd(8'h00, "status_rx_empty", 32'h1);

    // counters and clear
    step(); wr(8'h18, 4'b1111, 32'h0);
    step(); rd(8'h14, "instrs_clr0", 32'h0);
    instr_retire = 1'b1;
    repeat (6) step();
    step(); instr_retire = 1'b0; rd(8'h14, "instrs_7", 32'd7);
    step(); instr_retire = 1'b1; wr(8'h18, 4'b0100, 32'h0);
    step(); instr_retire = 1'b0; rd(8'h10, "cycles_after_clr", 32'h0);
    step(); rd(8'h14, "instrs_after_clr", 32'h0);

    // decode boundaries
    step(); rd(8'h0C, "unmapped_read", 32'h0);
    step(); rd(8'h08, "txdata_read", 32'h0);
    step(); addr = 32'h0000_0000; load_sel = 1'b1;
    expect_chk(K_RDATA, "non_io_read", 32'h0);

    // asynchronous reset while a byte is pending
    step(); wr(8'h08, 4'b0001, 32'hA5);
    step(); expect_chk(K_TXVD, "tx_pre_rst", 32'h1A5);
    step(); #1; rst_n = 1'b0;
    expect_chk(K_TXVD, "tx_async_rst", 32'h0);
    step(); rd(8'h00, "status_in_rst", 32'h1);
    step(); rst_n = 1'b1;
    step(); rd(8'h10, "cycles_post_rst", 32'h1);

    step();
    guard = 0;
    while ((sb_q.size() != 0 || tx_q.size() != 0) && guard < 20) begin
      step();
      guard++;
    end
    vectors++;
    if (sb_q.size() != 0 || tx_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover actual=%0d/%0d required=0/0", sb_q.size(), tx_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
